// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder now,
// subtractor and multiplier later): FSM state encodings and state type.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } sa_state_t;

endpackage

// File: rtl/full_adder_bit.sv
// Gate-level one-bit full adder: two xor/and half-adder stages whose
// generate terms are or-ed into the carry out.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p;
  logic g0;
  logic g1;

  xor u_x0 (p, a, b);
  and u_a0 (g0, a, b);
  xor u_x1 (s, p, cin);
  and u_a1 (g1, p, cin);
  or  u_o0 (co, g0, g1);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first,
// one bit per clock; result and carry-out are held until the next completion.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             co;

  full_adder_bit u_fa (
    .a   (opa[0]),
    .b   (opb[0]),
    .cin (carry),
    .s   (s),
    .co  (co)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_next = s;
    end else begin : g_acc_wn
      assign acc_next = {s, acc[WIDTH-1:1]};
    end
  endgenerate

  // Handshake: start is a request sampled only in IDLE or DONE (ignored in RUN);
  // A/B are captured on that same edge. done is a one-cycle Moore pulse marking
  // the first cycle in which sum/cout hold the new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            opa   <= A;
            opb   <= B;
            carry <= 1'b0;
            cnt   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= co;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= ST_DONE;
            sum   <= acc_next;
            cout  <= co;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed scenarios plus
// randomized operands against a plain-arithmetic reference model.
module tb_serial_adder;
  import serial_arith_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [1:0]       dbg_state;

  int n_checks;
  int n_errors;
  logic [WIDTH:0] exp_q[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: full-precision addition
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // driver: one start pulse, then wait (bounded) for done; inputs change #1 after posedge
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int lat, output int busy_cnt);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom_range(0, 255); B = $urandom_range(0, 255);
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, cout, sum, dbg_state} !== {1'b0, 1'b0, 1'b0, 8'h00, 2'(IDLE)}) begin
      n_errors++;
      $display("FAIL reset_state: busy=%b done=%b cout=%b sum=%h state=%0d, want 0 0 0 00 %0d",
               busy, done, cout, sum, dbg_state, IDLE);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [WIDTH:0] e;
    e = ref_add(8'h05, 8'h03);
    run_op(8'h05, 8'h03, lat, bc);
    n_checks++;
    if (lat !== WIDTH) begin
      n_errors++; $display("FAIL basic_latency: edges=%0d want %0d", lat, WIDTH);
    end
    n_checks++;
    if (bc !== WIDTH) begin
      n_errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, WIDTH);
    end
    n_checks++;
    if ({cout, sum} !== e || e !== 9'h008) begin
      n_errors++; $display("FAIL basic_sum: cout=%b sum=%h want 0 08", cout, sum);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== e) begin
      n_errors++; $display("FAIL basic_after_done: done=%b busy=%b sum=%h, want 0 0 held", done, busy, sum);
    end
  endtask

  task automatic test_corners();
    logic [WIDTH-1:0] ta [4];
    logic [WIDTH-1:0] tb [4];
    int lat, bc;
    ta[0] = 8'hFF; tb[0] = 8'h01;
    ta[1] = 8'hAA; tb[1] = 8'h55;
    ta[2] = 8'h00; tb[2] = 8'h00;
    ta[3] = 8'hFF; tb[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], lat, bc);
      n_checks++;
      if (lat !== WIDTH || {cout, sum} !== ref_add(ta[i], tb[i])) begin
        n_errors++;
        $display("FAIL corner_%0d: A=%h B=%h got cout=%b sum=%h lat=%0d want %h lat=%0d",
                 i, ta[i], tb[i], cout, sum, lat, ref_add(ta[i], tb[i]), WIDTH);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignored_start();
    int lat;
    A = 8'h10; B = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 2) begin start = 1'b1; A = 8'hFF; B = 8'hFF; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (lat !== WIDTH || {cout, sum} !== 9'h030) begin
      n_errors++;
      $display("FAIL ignored_start: lat=%0d cout=%b sum=%h want lat=%0d 0 30", lat, cout, sum, WIDTH);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    A = 8'h37; B = 8'h44; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({busy, done, cout, sum, dbg_state} !== {1'b0, 1'b0, 1'b0, 8'h00, 2'(IDLE)}) begin
      n_errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b cout=%b sum=%h state=%0d, want 0 0 0 00 %0d",
               busy, done, cout, sum, dbg_state, IDLE);
    end
    seen_done = 0;
    repeat (WIDTH + 4) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h00) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_errors++; $display("FAIL reset_no_done: %0d bad cycles after reset, want 0", seen_done);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    A = 8'h05; B = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== WIDTH || {cout, sum} !== ref_add(8'h05, 8'h03)) begin
      n_errors++; $display("FAIL b2b_first: lat=%0d sum=%h cout=%b want lat=%0d 08 0", n, sum, cout, WIDTH);
    end
    A = 8'h80; B = 8'h80;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_errors++; $display("FAIL b2b_reentry: busy=%b done=%b want 1 0", busy, done);
    end
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== WIDTH + 1 || {cout, sum} !== ref_add(8'h80, 8'h80)) begin
      n_errors++; $display("FAIL b2b_second: cycles=%0d cout=%b sum=%h want %0d 1 00", n, cout, sum, WIDTH + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, bc;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0] e;
    for (int i = 0; i < 1000; i++) begin
      a = WIDTH'($urandom_range(0, 255));
      b = WIDTH'($urandom_range(0, 255));
      exp_q.push_back(ref_add(a, b));
      run_op(a, b, lat, bc);
      e = exp_q.pop_front();
      n_checks++;
      if ({cout, sum} !== e || lat !== WIDTH || bc !== WIDTH) begin
        n_errors++;
        $display("FAIL random_%0d: A=%h B=%h got %h lat=%0d busy=%0d want %h lat=%0d busy=%0d",
                 i, a, b, {cout, sum}, lat, bc, e, WIDTH, WIDTH);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin
        n_errors++; $display("FAIL random_pulse_%0d: done=%b one cycle after done, want 0", i, done);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    test_reset();
    test_basic();
    test_corners();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
